bit_serializer: RTL

- Parallel-to-serial stage directly upstream of the pop_quiz sequence stage. Its d_out drives pop_quiz d_in.
- Accepts a WIDTH-bit word over a valid/ready handshake and emits it MSB-first, one bit per clk cycle.
- Supports back-to-back words with no bubble, so long bit patterns reach the downstream detector as a continuous stream.

---
 rtl/serializer_pkg.sv | 12 +
 rtl/bit_serializer.sv | 107 ++++++++++
 2 files changed

// File: rtl/serializer_pkg.sv
// Shared types and defaults for the bit_serializer parallel-to-serial stage.
package serializer_pkg;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } ser_state_e;

  localparam int   SER_DEFAULT_WIDTH = 8;
  localparam logic SER_IDLE_BIT      = 1'b0;

endpackage

// File: rtl/bit_serializer.sv
// MSB-first parallel-to-serial stage with a valid/ready input and gapless back-to-back frames.
// Define SERIALIZER_PARITY_EN to append an even-parity bit after the LSB of each word.
module bit_serializer
  import serializer_pkg::*;
#(
  parameter int   WIDTH    = SER_DEFAULT_WIDTH,
  parameter logic IDLE_BIT = SER_IDLE_BIT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             d_out,
  output logic             d_valid,
  output logic             d_last,
  output logic             busy
);

`ifdef SERIALIZER_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam int               CNT_W    = $clog2(NBITS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBITS - 1);

  ser_state_e       state, state_n;
  logic [WIDTH-1:0] shift_reg, shift_n;
  logic [CNT_W-1:0] bit_cnt, cnt_n;
  logic             d_out_n, d_valid_n, d_last_n;
  logic             transfer;
`ifdef SERIALIZER_PARITY_EN
  logic             parity_bit, parity_n;
`endif

  assign ready_out = (state == S_IDLE) || (bit_cnt == LAST_CNT);
  assign transfer  = valid_in && ready_out;
  assign busy      = (state == S_SHIFT);

  // NOTE: every signal gets its hold value before the branches below, so no latch is inferred.
  always_comb begin
    state_n   = state;
    shift_n   = shift_reg;
    cnt_n     = bit_cnt;
    d_out_n   = d_out;
    d_valid_n = d_valid;
    d_last_n  = d_last;
`ifdef SERIALIZER_PARITY_EN
    parity_n  = parity_bit;
`endif
    if (transfer) begin
      // Reload also covers the last-bit edge, which is what keeps frames gapless.
      state_n   = S_SHIFT;
      shift_n   = data_in;
      cnt_n     = '0;
      d_out_n   = data_in[WIDTH-1];
      d_valid_n = 1'b1;
      d_last_n  = 1'b0;
`ifdef SERIALIZER_PARITY_EN
      parity_n  = ^data_in;
`endif
    end else if (state == S_SHIFT) begin
      if (bit_cnt == LAST_CNT) begin
        state_n   = S_IDLE;
        d_out_n   = IDLE_BIT;
        d_valid_n = 1'b0;
        d_last_n  = 1'b0;
      end else begin
        shift_n  = shift_reg << 1;
        cnt_n    = bit_cnt + 1'b1;
        d_last_n = (cnt_n == LAST_CNT);
`ifdef SERIALIZER_PARITY_EN
        d_out_n  = (bit_cnt == CNT_W'(WIDTH - 1)) ? parity_bit : shift_reg[WIDTH-2];
`else
        d_out_n  = shift_reg[WIDTH-2];
`endif
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      d_out     <= IDLE_BIT;
      d_valid   <= 1'b0;
      d_last    <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      shift_reg <= shift_n;
      bit_cnt   <= cnt_n;
      d_out     <= d_out_n;
      d_valid   <= d_valid_n;
      d_last    <= d_last_n;
`ifdef SERIALIZER_PARITY_EN
      parity_bit <= parity_n;
`endif
    end
  end

endmodule
